// File: rtl/rle_encoder.sv
// rle_encoder: JPEG run-length symbol generator for zig-zag ordered blocks.
// Ports: clk, nrst (async active-low), din/din_valid (coefficient in),
//        sym_valid/sym_type/sym_zrl/sym_run/sym_size/sym_amp/sym_last
//        (registered symbol out, 1-cycle latency, 1-cycle valid pulse).
module rle_encoder #(
   parameter int DIN_W = 8
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic signed [DIN_W-1:0] din,
   input  logic                    din_valid,
   output logic                    sym_valid,
   output logic [1:0]              sym_type,
   output logic [1:0]              sym_zrl,
   output logic [3:0]              sym_run,
   output logic [3:0]              sym_size,
   output logic [DIN_W:0]          sym_amp,
   output logic                    sym_last
);

   localparam int AW = DIN_W + 1;

   typedef enum logic [1:0] {
      SYM_DC  = 2'd0,
      SYM_AC  = 2'd1,
      SYM_EOB = 2'd2
   } sym_e;

   // Position of the incoming coefficient inside the block.
   logic [5:0]              pos, pos_nx;
   logic [3:0]              zero_run, zero_run_nx;
   // One bit wider than needed so an impossible overflow is observable.
   logic [2:0]              zrl_pend, zrl_pend_nx;
   logic signed [DIN_W-1:0] prev_dc, prev_dc_nx;

   logic                    o_valid;
   sym_e                    o_type;
   logic [1:0]              o_zrl;
   logic [3:0]              o_run;
   logic [3:0]              o_size;
   logic [AW-1:0]           o_amp;
   logic                    o_last;

   logic signed [AW-1:0]    din_x;
   logic signed [AW-1:0]    prev_x;
   logic signed [AW-1:0]    diff;
   logic signed [AW-1:0]    val;
   logic signed [AW-1:0]    mag;
   logic signed [AW-1:0]    ones;
   logic [3:0]              size_v;
   logic [AW-1:0]           amp_v;

   logic                    is_dc;
   logic                    is_end;
   logic                    din_zero;

   function automatic logic [3:0] size_of(input logic [AW-1:0] m);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < AW; i++) begin
         if (m[i]) s = 4'(i + 1);
      end
      return s;
   endfunction

   function automatic logic [AW-1:0] low_mask(input logic [3:0] s);
      logic [AW-1:0] m;
      m = '0;
      for (int i = 0; i < AW; i++) begin
         m[i] = (i < int'(s));
      end
      return m;
   endfunction

   // Size/amplitude path, shared by DC difference and AC value.
   always_comb begin
      din_x  = AW'(din);
      prev_x = AW'(prev_dc);
      diff   = din_x - prev_x;
      val    = is_dc ? diff : din_x;
      // Magnitude fits in AW bits for every reachable value, including
      // the most negative coefficient and the widest DC difference.
      mag    = val[AW-1] ? -val : val;
      // Negative values send the one's complement of the magnitude.
      ones   = val[AW-1] ? val - AW'(1) : val;
      size_v = size_of(mag);
      amp_v  = ones & low_mask(size_v);
   end

   assign is_dc    = (pos == 6'd0);
   assign is_end   = (pos == 6'd63);
   assign din_zero = (din == '0);

   always_comb begin
      pos_nx      = pos;
      zero_run_nx = zero_run;
      zrl_pend_nx = zrl_pend;
      prev_dc_nx  = prev_dc;
      o_valid     = 1'b0;
      o_type      = SYM_DC;
      o_zrl       = '0;
      o_run       = '0;
      o_size      = '0;
      o_amp       = '0;
      o_last      = 1'b0;

      if (din_valid) begin
         pos_nx = pos + 6'd1;
         unique case (1'b1)
            is_dc: begin
               prev_dc_nx  = din;
               zero_run_nx = '0;
               zrl_pend_nx = '0;
               o_valid     = 1'b1;
               o_type      = SYM_DC;
               o_size      = size_v;
               o_amp       = amp_v;
            end
            (!is_dc && !din_zero): begin
               zero_run_nx = '0;
               zrl_pend_nx = '0;
               o_valid     = 1'b1;
               o_type      = SYM_AC;
               o_zrl       = zrl_pend[1:0];
               o_run       = zero_run;
               o_size      = size_v;
               o_amp       = amp_v;
               o_last      = is_end;
            end
            (!is_dc && din_zero && is_end): begin
               // Trailing zeros collapse into EOB; pending run is dropped.
               zero_run_nx = '0;
               zrl_pend_nx = '0;
               o_valid     = 1'b1;
               o_type      = SYM_EOB;
               o_last      = 1'b1;
            end
            (!is_dc && din_zero && !is_end): begin
               if (zero_run == 4'd15) begin
                  zero_run_nx = '0;
                  zrl_pend_nx = zrl_pend + 3'd1;
               end else begin
                  zero_run_nx = zero_run + 4'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pos       <= '0;
         zero_run  <= '0;
         zrl_pend  <= '0;
         prev_dc   <= '0;
         sym_valid <= 1'b0;
         sym_type  <= '0;
         sym_zrl   <= '0;
         sym_run   <= '0;
         sym_size  <= '0;
         sym_amp   <= '0;
         sym_last  <= 1'b0;
      end else begin
         pos       <= pos_nx;
         zero_run  <= zero_run_nx;
         zrl_pend  <= zrl_pend_nx;
         prev_dc   <= prev_dc_nx;
         sym_valid <= o_valid;
         sym_type  <= o_type;
         sym_zrl   <= o_zrl;
         sym_run   <= o_run;
         sym_size  <= o_size;
         sym_amp   <= o_amp;
         sym_last  <= o_last;
      end
   end

   // 63 AC slots can hold at most three full 16-zero runs.
   zrl_bound: assert property (
      @(posedge clk) disable iff (!nrst) zrl_pend <= 3'd3
   );

endmodule

// File: tb/tb_rle_encoder.sv
// tb_rle_encoder: randomized scoreboard bench for rle_encoder.
// Block-level reference model feeds a queue; a monitor checks outputs.
module tb_rle_encoder;

   localparam int DIN_W = 8;
   localparam int LO    = -(1 << (DIN_W - 1));
   localparam int HI    = (1 << (DIN_W - 1)) - 1;

   logic                    clk;
   logic                    nrst;
   logic signed [DIN_W-1:0] din;
   logic                    din_valid;
   logic                    sym_valid;
   logic [1:0]              sym_type;
   logic [1:0]              sym_zrl;
   logic [3:0]              sym_run;
   logic [3:0]              sym_size;
   logic [DIN_W:0]          sym_amp;
   logic                    sym_last;

   rle_encoder #(.DIN_W(DIN_W)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .din       (din),
      .din_valid (din_valid),
      .sym_valid (sym_valid),
      .sym_type  (sym_type),
      .sym_zrl   (sym_zrl),
      .sym_run   (sym_run),
      .sym_size  (sym_size),
      .sym_amp   (sym_amp),
      .sym_last  (sym_last)
   );

   typedef struct {
      int idx;
      int typ;
      int zrl;
      int run;
      int size;
      int amp;
      int last;
      int cyc;
   } sym_t;

   sym_t exp_q[$];
   sym_t mq[$];
   int   blk[64];
   int   prev_dc_m;
   int   cyc;
   int   vectors;
   int   miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void size_amp(input int v, output int s, output int a);
      int m;
      m = (v < 0) ? -v : v;
      s = 0;
      while (m > 0) begin
         s++;
         m = m >> 1;
      end
      a = ((v < 0) ? v - 1 : v) & ((1 << s) - 1);
   endfunction

   function automatic sym_t mk(input int idx, input int typ, input int zrl,
                               input int run, input int v, input int last);
      sym_t e;
      int   s;
      int   a;
      size_amp(v, s, a);
      e.idx  = idx;
      e.typ  = typ;
      e.zrl  = zrl;
      e.run  = run;
      e.size = s;
      e.amp  = a;
      e.last = last;
      e.cyc  = 0;
      return e;
   endfunction

   // Whole-block view: zeros between nonzeros form one count,
   // split into 16-zero ZRL groups plus a remainder run.
   function automatic void model_block();
      int cnt;
      mq.delete();
      mq.push_back(mk(0, 0, 0, 0, blk[0] - prev_dc_m, 0));
      prev_dc_m = blk[0];
      cnt = 0;
      for (int k = 1; k < 64; k++) begin
         if (blk[k] == 0) begin
            cnt++;
         end else begin
            mq.push_back(mk(k, 1, cnt / 16, cnt % 16, blk[k],
                            (k == 63) ? 1 : 0));
            cnt = 0;
         end
      end
      if (blk[63] == 0) mq.push_back(mk(63, 2, 0, 0, 0, 1));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, int'(sym_valid), 0);
      chk({tag, "_type"}, int'(sym_type), 0);
      chk({tag, "_zrl"}, int'(sym_zrl), 0);
      chk({tag, "_run"}, int'(sym_run), 0);
      chk({tag, "_size"}, int'(sym_size), 0);
      chk({tag, "_amp"}, int'(sym_amp), 0);
      chk({tag, "_last"}, int'(sym_last), 0);
   endtask

   // gap: 0 none, 1 every other cycle, 2 random
   task automatic run_block(input int n, input int gap);
      sym_t e;
      model_block();
      for (int k = 0; k < n; k++) begin
         if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) begin
            repeat ((gap == 1) ? 1 : int'($urandom_range(1, 3))) begin
               @(negedge clk);
               din_valid = 1'b0;
               din = DIN_W'($urandom);
            end
         end
         @(negedge clk);
         din = DIN_W'(blk[k]);
         din_valid = 1'b1;
         while (mq.size() > 0 && mq[0].idx == k) begin
            e = mq.pop_front();
            e.cyc = cyc;
            exp_q.push_back(e);
         end
      end
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   task automatic clear_blk();
      for (int k = 0; k < 64; k++) blk[k] = 0;
   endtask

   function automatic int rnd_val();
      int v;
      v = int'($urandom_range(0, (1 << DIN_W) - 1)) + LO;
      return v;
   endfunction

   function automatic int rnd_ac();
      int r;
      int v;
      r = int'($urandom_range(0, 9));
      if (r < 7) return 0;
      if (r == 7) return ($urandom_range(0, 1) == 1) ? LO : HI;
      v = rnd_val();
      if (v == 0) v = 1;
      return v;
   endfunction

   always @(negedge clk) begin
      sym_t e;
      if (nrst && sym_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_sym: type %0d run %0d size %0d amp %0d",
                     sym_type, sym_run, sym_size, sym_amp);
         end else begin
            e = exp_q.pop_front();
            if (int'(sym_type) != e.typ || int'(sym_zrl) != e.zrl ||
                int'(sym_run) != e.run || int'(sym_size) != e.size ||
                int'(sym_amp) != e.amp || int'(sym_last) != e.last ||
                cyc != e.cyc + 1) begin
               miscompares++;
               $display({"FAIL sym idx %0d: got t%0d z%0d r%0d s%0d a%0h l%0d",
                         " c%0d, expected t%0d z%0d r%0d s%0d a%0h l%0d c%0d"},
                        e.idx, sym_type, sym_zrl, sym_run, sym_size,
                        sym_amp, sym_last, cyc, e.typ, e.zrl, e.run,
                        e.size, e.amp, e.last, e.cyc + 1);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: run did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      prev_dc_m   = 0;
      nrst        = 1'b0;
      din_valid   = 1'b0;
      din         = '0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      #1 nrst = 1'b1;

      clear_blk();
      blk[0] = 5;
      run_block(64, 0);
      blk[0] = 2;
      run_block(64, 0);
      run_block(64, 0);

      clear_blk();
      blk[3] = -1;
      run_block(64, 0);

      clear_blk();
      blk[21] = 7;
      run_block(64, 0);

      clear_blk();
      blk[63] = LO;
      run_block(64, 0);

      for (int k = 0; k < 64; k++) blk[k] = rnd_ac();
      blk[0] = 40;
      run_block(10, 0);
      @(posedge clk);
      #2 nrst = 1'b0;
      #1 chk_idle_outputs("async_rst");
      prev_dc_m = 0;
      @(negedge clk);
      #1 nrst = 1'b1;

      clear_blk();
      blk[0] = 9;
      run_block(64, 0);
      clear_blk();
      blk[21] = 7;
      blk[0] = 9;
      run_block(64, 1);

      for (int b = 0; b < 24; b++) begin
         for (int k = 1; k < 64; k++) blk[k] = rnd_ac();
         blk[0] = rnd_val();
         run_block(64, (b % 3 == 0) ? 0 : 2);
      end

      repeat (4) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d symbols missing, expected 0",
                  exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rle_encoder.md
Name: rle_encoder

Overview:
- Consumes the zig-zag-ordered quantized coefficient stream, 64 coefficients per 8x8 block, one per `din_valid`.
- Produces JPEG entropy symbols for the downstream Huffman stage:
  - DC: DPCM difference plus size category.
  - AC: zero-run, size and amplitude, with a count of pending ZRLs.
  - EOB at end of block.
- Single clock domain, streaming, no backpressure; accepts one coefficient per cycle at full rate.

Parameters:
- DIN_W, 8, signed coefficient width; legal range 2..14. Sets amplitude width (DIN_W+1) and size range 0..DIN_W+1.

Ports:
- clk  in  1  clock, all state updates on rising edge
- nrst  in  1  asynchronous active-low reset
- din  in  DIN_W  signed quantized coefficient, zig-zag order
- din_valid  in  1  din valid this cycle
- sym_valid  out  1  symbol outputs valid this cycle
- sym_type  out  2  0=DC, 1=AC, 2=EOB, 3 unused
- sym_zrl  out  2  number of ZRL (F/0) codes to emit before this AC symbol, 0..3
- sym_run  out  4  zero run preceding this AC coefficient, 0..15
- sym_size  out  4  size category
- sym_amp  out  DIN_W+1  amplitude bits, low sym_size bits significant, upper bits zero
- sym_last  out  1  final symbol of the current block

Behaviour:
- Reset (nrst low, asynchronous): all outputs 0; `pos`=0, `zero_run`=0, `zrl_pend`=0, `prev_dc`=0. Reset mid-block discards the partial block; the next accepted coefficient is treated as DC.
- Latency: every output is registered exactly 1 cycle after the accepting `din_valid` edge. `sym_valid` is a 1-cycle pulse; at most one symbol per accepted coefficient.
- Position counter `pos` (6 bits):
  - Increments on each accepted coefficient.
  - Wraps 63 -> 0.
  - Idle cycles (`din_valid`=0) change nothing.
- DC (pos==0):
  - `diff` = din - prev_dc, computed in DIN_W+1 bits signed.
  - prev_dc <= din.
  - Emit sym_type=0, with size and amplitude of `diff`.
  - sym_zrl=0, sym_run=0.
  - Always emitted, including when diff is 0 (size 0, amp 0).
- AC zero (pos 1..63, din==0):
  - If `zero_run`==15: `zero_run` <= 0 and `zrl_pend`++.
  - Else `zero_run`++.
  - No symbol is emitted, except the EOB rule below.
- AC nonzero:
  - Emit sym_type=1, sym_run=`zero_run`, sym_zrl=`zrl_pend`, plus size and amplitude of din.
  - Clear `zero_run` and `zrl_pend`.
- EOB: when the coefficient at pos==63 is zero, emit sym_type=2 with run/size/amp/zrl all 0 and sym_last=1. Pending ZRLs and run are discarded and cleared.
- sym_last: 1 on EOB, or on an AC symbol from pos==63. No EOB follows a nonzero coefficient at pos 63.
- `zrl_pend` saturation: cannot exceed 3 (63 ACs max); no overflow logic is required. An assertion flags `zrl_pend`>3.
- Size category: minimum bit count of |v|; 0 when v==0.
- Amplitude encoding:
  - v>0: the low size bits of v.
  - v<0: the low size bits of (v-1) in two's complement, i.e. the one's complement of |v|.
  - Upper bits forced to 0.
- Arithmetic: all in DIN_W+1 bits; |v| of the most negative DIN_W value is handled (size DIN_W).
- Gaps in `din_valid` anywhere, including within a block, do not affect the symbol stream contents.

Test Plan:
1. Reset, block1 = DC 5 then 63 zeros, din_valid every cycle -> DC sym (size 3, amp 5), then EOB with sym_last=1 one cycle after the 64th input; exactly 2 sym_valid pulses.
2. Block2 DC=2 after block1 -> diff -3: type 0, size 2, amp 2'b00. Then DC=2 again in block3 -> size 0, amp 0, still emitted.
3. DC 0; AC 0,0,-1 then zeros -> AC sym run 2, size 1, amp 0, zrl 0; then EOB.
4. DC 0; 20 zeros then 7 at pos 21; rest zero -> AC run 4, zrl 1, size 3, amp 7; then EOB.
5. DC 0; zeros to pos 62; -128 at pos 63 -> AC zrl 3, run 14, size 8, amp 8'h7F, sym_last=1; no EOB follows.
6. Reset mid-block: drive 10 coefficients, pulse nrst low asynchronously between edges -> outputs 0 immediately. Next coefficient 9 -> DC diff 9 (prev_dc 0), size 4, amp 9. Repeat scenario 4 with din_valid toggling every other cycle -> identical symbol sequence.
